// File: rtl/x2050ls.sv
// x2050ls - 2050 local storage array.
// 64 words x 32 data bits with one odd-parity bit per byte lane. Reads are
// early (they return the word as it stood at the start of the cycle) and writes
// are late (they land at the end of the cycle). A clear sweep runs out of reset
// and on command. A parity checker on the read side keeps sticky error state.
//
// state    | meaning
// ---------+------------------------------------------------------------------
// ST_CLEAR | sweeping: word[cnt] <= 0 / parity 1111, rd/wr/clear ignored
// ST_READY | servicing rd/wr; i_clear restarts the sweep from word 0
//
// Byte lane k is i_wdata[8k+7:8k] and is controlled by i_wmask[k],
// i_inject_perr[k] and o_rpar[k]. Lane 3 holds the architectural byte 0.

module x2050ls #(
    parameter int ADDR_W = 6,
    parameter int BYTES  = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [ADDR_W-1:0]    i_lsa,
    input  logic                 i_rd,
    input  logic                 i_wr,
    input  logic [BYTES-1:0]     i_wmask,
    input  logic [8*BYTES-1:0]   i_wdata,
    input  logic [BYTES-1:0]     i_inject_perr,
    input  logic                 i_clear,
    input  logic                 i_perr_clr,
    output logic [8*BYTES-1:0]   o_rdata,
    output logic [BYTES-1:0]     o_rpar,
    output logic                 o_rvalid,
    output logic                 o_busy,
    output logic                 o_perr,
    output logic [BYTES-1:0]     o_perr_byte,
    output logic [ADDR_W-1:0]    o_perr_addr
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int DATA_W = 8 * BYTES;

    localparam logic ST_CLEAR = 1'b0;
    localparam logic ST_READY = 1'b1;

    logic                state;
    logic [ADDR_W-1:0]   cnt;
    logic [ADDR_W-1:0]   rd_addr;
    logic [BYTES-1:0]    lane_fail;
    logic                any_fail;
    logic                accept_rd;
    logic                accept_wr;

    // Storage: the array itself is never reset; the sweep establishes contents.
    logic [DATA_W-1:0]   mem_data [DEPTH];
    logic [BYTES-1:0]    mem_par  [DEPTH];

    assign o_busy    = (state == ST_CLEAR);
    assign accept_rd = (state == ST_READY) && i_rd;
    assign accept_wr = (state == ST_READY) && i_wr;

    // Sweep sequencer: walk every word once, then open the array for access.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    cnt <= cnt + ADDR_W'(1);
                    if (cnt == {ADDR_W{1'b1}}) begin
                        state <= ST_READY;
                    end
                end
                default: begin
                    if (i_clear) begin
                        state <= ST_CLEAR;
                        cnt   <= '0;
                    end
                end
            endcase
        end
    end

    // Array write port: sweep writes a zero word, otherwise masked byte writes.
    always_ff @(posedge i_clk) begin
        if (state == ST_CLEAR) begin
            mem_data[cnt] <= '0;
            mem_par[cnt]  <= '1;
        end else if (accept_wr) begin
            for (int k = 0; k < BYTES; k++) begin
                if (i_wmask[k]) begin
                    mem_data[i_lsa][8*k +: 8] <= i_wdata[8*k +: 8];
                    mem_par[i_lsa][k]         <= (~^i_wdata[8*k +: 8]) ^ i_inject_perr[k];
                end
            end
        end
    end

    // Read port: capture the pre-write word; data holds until the next read.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_rdata  <= '0;
            o_rpar   <= '1;
            o_rvalid <= 1'b0;
            rd_addr  <= '0;
        end else begin
            o_rvalid <= 1'b0;
            if (accept_rd) begin
                o_rdata  <= mem_data[i_lsa];
                o_rpar   <= mem_par[i_lsa];
                o_rvalid <= 1'b1;
                rd_addr  <= i_lsa;
            end
        end
    end

    // Per-lane odd-parity check of the word currently presented with o_rvalid.
    always_comb begin
        lane_fail = '0;
        if (o_rvalid) begin
            for (int k = 0; k < BYTES; k++) begin
                lane_fail[k] = ~(^{o_rdata[8*k +: 8], o_rpar[k]});
            end
        end
    end

    assign any_fail = |lane_fail;

    // Sticky error capture; a failure in the same cycle as a clear survives it.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_perr      <= 1'b0;
            o_perr_byte <= '0;
            o_perr_addr <= '0;
        end else if (any_fail) begin
            o_perr      <= 1'b1;
            o_perr_byte <= (i_perr_clr ? '0 : o_perr_byte) | lane_fail;
            if (i_perr_clr || !o_perr) begin
                o_perr_addr <= rd_addr;
            end
        end else if (i_perr_clr) begin
            o_perr      <= 1'b0;
            o_perr_byte <= '0;
            o_perr_addr <= '0;
        end
    end

endmodule

// File: tb/tb_x2050ls.sv
// Bench for x2050ls: directed vectors, a word-level model of the store and a
// per-cycle compare against it, plus literal expectations at key points.

module tb_x2050ls;

    logic        clk;
    logic        rst_n;
    logic [5:0]  lsa;
    logic        rd;
    logic        wr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [3:0]  inject;
    logic        clr;
    logic        pclr;
    logic [31:0] rdata;
    logic [3:0]  rpar;
    logic        rvalid;
    logic        busy;
    logic        perr;
    logic [3:0]  perr_byte;
    logic [5:0]  perr_addr;

    int n_checks = 0;
    int n_fail   = 0;

    x2050ls dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_lsa         (lsa),
        .i_rd          (rd),
        .i_wr          (wr),
        .i_wmask       (wmask),
        .i_wdata       (wdata),
        .i_inject_perr (inject),
        .i_clear       (clr),
        .i_perr_clr    (pclr),
        .o_rdata       (rdata),
        .o_rpar        (rpar),
        .o_rvalid      (rvalid),
        .o_busy        (busy),
        .o_perr        (perr),
        .o_perr_byte   (perr_byte),
        .o_perr_addr   (perr_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-level model of the store and of the visible outputs.
    logic [31:0] m_mem [64];
    logic [3:0]  m_par [64];
    logic [31:0] m_rdata;
    logic [3:0]  m_rpar;
    logic        m_rvalid;
    logic        m_perr;
    logic [3:0]  m_perr_byte;
    logic [5:0]  m_perr_addr;
    logic [5:0]  m_last_addr;
    int          m_sweep_left;

    always @(posedge clk or negedge rst_n) begin
        logic [3:0] fails;
        if (!rst_n) begin
            m_rdata      = 32'h0;
            m_rpar       = 4'hF;
            m_rvalid     = 1'b0;
            m_perr       = 1'b0;
            m_perr_byte  = 4'h0;
            m_perr_addr  = 6'h0;
            m_last_addr  = 6'h0;
            m_sweep_left = 64;
        end else begin
            fails = 4'h0;
            if (m_rvalid) begin
                for (int k = 0; k < 4; k++) begin
                    if ((($countones(m_rdata[8*k +: 8]) + int'(m_rpar[k])) % 2) == 0) fails[k] = 1'b1;
                end
            end
            if (pclr) begin
                m_perr      = 1'b0;
                m_perr_byte = 4'h0;
                m_perr_addr = 6'h0;
            end
            if (fails != 4'h0) begin
                if (!m_perr) m_perr_addr = m_last_addr;
                m_perr      = 1'b1;
                m_perr_byte = m_perr_byte | fails;
            end
            if (m_sweep_left > 0) begin
                m_mem[64 - m_sweep_left] = 32'h0;
                m_par[64 - m_sweep_left] = 4'hF;
                m_sweep_left = m_sweep_left - 1;
                m_rvalid = 1'b0;
            end else begin
                m_rvalid = rd;
                if (rd) begin
                    m_rdata     = m_mem[lsa];
                    m_rpar      = m_par[lsa];
                    m_last_addr = lsa;
                end
                if (wr) begin
                    for (int k = 0; k < 4; k++) begin
                        if (wmask[k]) begin
                            m_mem[lsa][8*k +: 8] = wdata[8*k +: 8];
                            m_par[lsa][k] = (($countones(wdata[8*k +: 8]) % 2) == 0) ^ inject[k];
                        end
                    end
                end
                if (clr) m_sweep_left = 64;
            end
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            n_checks++;
            if (rdata !== m_rdata || rpar !== m_rpar || rvalid !== m_rvalid ||
                busy !== (m_sweep_left > 0) || perr !== m_perr ||
                perr_byte !== m_perr_byte || perr_addr !== m_perr_addr) begin
                n_fail++;
                $display("FAIL cycle_cmp t=%0t got rdata=%h rpar=%b rvalid=%b busy=%b perr=%b pbyte=%b paddr=%h want rdata=%h rpar=%b rvalid=%b busy=%b perr=%b pbyte=%b paddr=%h",
                         $time, rdata, rpar, rvalid, busy, perr, perr_byte, perr_addr,
                         m_rdata, m_rpar, m_rvalid, (m_sweep_left > 0), m_perr, m_perr_byte, m_perr_addr);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        rd = 1'b0; wr = 1'b0; wmask = 4'h0; wdata = 32'h0;
        inject = 4'h0; clr = 1'b0; pclr = 1'b0;
    endtask

    task automatic op_wr(input logic [5:0] a, input logic [31:0] d,
                         input logic [3:0] m, input logic [3:0] j);
        idle(); wr = 1'b1; lsa = a; wdata = d; wmask = m; inject = j;
        step(); idle();
    endtask

    task automatic op_rd(input logic [5:0] a);
        idle(); rd = 1'b1; lsa = a;
        step(); idle();
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_rdata"}, rdata, 32'h0);
        chk({tag, "_rpar"}, {28'h0, rpar}, 32'hF);
        chk({tag, "_rvalid"}, {31'h0, rvalid}, 32'h0);
        chk({tag, "_busy"}, {31'h0, busy}, 32'h1);
        chk({tag, "_perr"}, {27'h0, perr, perr_byte}, 32'h0);
        chk({tag, "_paddr"}, {26'h0, perr_addr}, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0;
        lsa   = 6'h0;
        idle();
        repeat (3) @(negedge clk);
        chk_reset_values("rst");
        rst_n = 1'b1;
        wait_busy(n);
        chk("sweep_len", n, 64);

        op_rd(6'h3F);
        chk("rd3f_data", rdata, 32'h0);
        chk("rd3f_par", {28'h0, rpar}, 32'hF);
        step();
        chk("rd3f_perr", {31'h0, perr}, 32'h0);

        op_wr(6'h11, 32'h12345678, 4'hF, 4'h0);
        op_rd(6'h11);
        chk("rd11_data", rdata, 32'h12345678);
        chk("rd11_par", {28'h0, rpar}, 32'hB);
        chk("rd11_valid", {31'h0, rvalid}, 32'h1);
        step();
        chk("rd11_valid_pulse", {31'h0, rvalid}, 32'h0);

        op_wr(6'h23, 32'hFFFFFFFF, 4'hF, 4'h0);
        op_wr(6'h23, 32'h0, 4'b0100, 4'h0);
        op_rd(6'h23);
        chk("rd23_data", rdata, 32'hFF00FFFF);
        chk("rd23_par", {28'h0, rpar}, 32'hF);

        idle(); rd = 1'b1; wr = 1'b1; lsa = 6'h05; wdata = 32'hA5A5A5A5; wmask = 4'hF;
        step(); idle();
        chk("rdwr05_old", rdata, 32'h0);
        op_rd(6'h05);
        chk("rd05_new", rdata, 32'hA5A5A5A5);

        op_wr(6'h30, 32'h0, 4'hF, 4'b0010);
        op_rd(6'h30);
        step();
        chk("perr_set", {31'h0, perr}, 32'h1);
        chk("perr_byte1", {28'h0, perr_byte}, 32'h2);
        chk("perr_addr1", {26'h0, perr_addr}, 32'h30);
        op_wr(6'h31, 32'h0000_00C3, 4'hF, 4'b0001);
        op_rd(6'h31);
        step();
        chk("perr_byte2", {28'h0, perr_byte}, 32'h3);
        chk("perr_addr2", {26'h0, perr_addr}, 32'h30);
        pclr = 1'b1;
        step(); idle();
        chk("perr_clr", {21'h0, perr, perr_byte, perr_addr}, 32'h0);

        idle(); clr = 1'b1; rd = 1'b1; lsa = 6'h11;
        step();
        clr = 1'b0;
        chk("clr_rd_serviced", rdata, 32'h12345678);
        wait_busy(n);
        idle();
        chk("clear_len", n, 64);
        op_rd(6'h11);
        chk("clr_rd11", rdata, 32'h0);
        op_rd(6'h23);
        chk("clr_rd23", rdata, 32'h0);
        op_rd(6'h05);
        chk("clr_rd05", rdata, 32'h0);
        op_rd(6'h30);
        chk("clr_rd30_par", {28'h0, rpar}, 32'hF);
        step();
        chk("clr_no_perr", {31'h0, perr}, 32'h0);

        op_wr(6'h11, 32'hDEADBEEF, 4'hF, 4'h4);
        op_rd(6'h11);
        chk("pre_rst_data", rdata, 32'hDEADBEEF);
        #2 rst_n = 1'b0;
        #1 chk_reset_values("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        wait_busy(n);
        chk("resweep_len", n, 64);
        op_rd(6'h11);
        chk("resweep_rd11", rdata, 32'h0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
